// File: rtl/frame_buffer_dp.sv
// Dual-port pixel frame buffer: one write port, one read port with RD_LAT of 1 or 2, and a clear sequencer.
// Optional macro FB_BYPASS_EN: a same-edge read and write to one address return the new write data.
`timescale 1ns/1ps
module frame_buffer_dp #(
    parameter int unsigned    DW      = 16,
    parameter int unsigned    AW      = 17,
    parameter int unsigned    DEPTH   = 76800,
    parameter int unsigned    RD_LAT  = 1,
    parameter logic [DW-1:0]  CLR_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    input  logic          regwrite,
    input  logic [AW-1:0] addr_out,
    input  logic          regread,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    input  logic          clear_req,
    output logic          busy,
    output logic          wr_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [DW-1:0] mem_r [DEPTH];
    state_t        state_r;
    logic [AW-1:0] clr_cnt_r;
    logic          busy_r;
    logic          wr_err_r;

    logic          wr_in_range_s;
    logic          rd_in_range_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          clr_we_s;
    logic [DW-1:0] rd_word_s;

    if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
        $error("frame_buffer_dp: DEPTH must be between 1 and 2**AW");
    end

    assign wr_in_range_s = ({1'b0, addr_in} < DEPTH_W);
    assign rd_in_range_s = ({1'b0, addr_out} < DEPTH_W);
    assign wr_acc_s      = regwrite && !busy_r && wr_in_range_s;
    assign rd_acc_s      = regread && !busy_r;
    assign clr_we_s      = (state_r == CLEAR) && !rst;
    assign busy          = busy_r;
    assign wr_err        = wr_err_r;

    // Read word selection; out-of-range addresses read as zero
    always_comb begin
        rd_word_s = {DW{1'b0}};
        if (rd_in_range_s) begin
            rd_word_s = mem_r[addr_out];
`ifdef FB_BYPASS_EN
            if (wr_acc_s && (addr_in == addr_out)) begin
                rd_word_s = data_in;
            end else begin
                rd_word_s = mem_r[addr_out];
            end
`endif
        end else begin
            rd_word_s = {DW{1'b0}};
        end
    end

    // Memory array; contents survive reset, sequencer and user writes never coincide
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we_s) begin
                mem_r[clr_cnt_r] <= CLR_VAL;
            end else if (wr_acc_s) begin
                mem_r[addr_in] <= data_in;
            end
        end
    end

    // Clear sequencer with registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            clr_cnt_r <= {AW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear_req) begin
                        state_r   <= CLEAR;
                        busy_r    <= 1'b1;
                        clr_cnt_r <= {AW{1'b0}};
                    end
                end
                CLEAR: begin
                    if (clr_cnt_r == LAST_IDX) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range write flag, one cycle after the rejected write
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= regwrite && !busy_r && !wr_in_range_s;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        // Single-stage read result register
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out   <= {DW{1'b0}};
                data_valid <= 1'b0;
            end else begin
                data_valid <= rd_acc_s;
                if (rd_acc_s) begin
                    data_out <= rd_word_s;
                end
            end
        end
    end else if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] pipe_data_r;
        logic          pipe_valid_r;
        // Two-stage read pipeline; data_out only moves when a result arrives
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_data_r  <= {DW{1'b0}};
                pipe_valid_r <= 1'b0;
                data_out     <= {DW{1'b0}};
                data_valid   <= 1'b0;
            end else begin
                pipe_valid_r <= rd_acc_s;
                pipe_data_r  <= rd_word_s;
                data_valid   <= pipe_valid_r;
                if (pipe_valid_r) begin
                    data_out <= pipe_data_r;
                end
            end
        end
    end else begin : g_bad_lat
        $error("frame_buffer_dp: RD_LAT must be 1 or 2");
    end

endmodule

// File: doc/frame_buffer_dp.md
Name: frame_buffer_dp

Overview:
- Parametrised dual-port pixel frame buffer for the camera datapath. Next generation of buffer_ram_dp.
- One write port (camera capture side) and one read port (display/VGA side), both on a single clock.
- Adds over the fixed 16-bit × 2^17 RAM: configurable width, depth and read latency; a read-valid strobe; out-of-range write flagging; a hardware frame-clear sequencer.
- Instanced between the capture block and the display controller.

Parameters:
- DW, 16: pixel data width in bits (RGB565 by default).
- AW, 17: address width in bits.
- DEPTH, 76800: number of pixel words (320×240 QVGA); must satisfy DEPTH ≤ 2^AW.
- RD_LAT, 1: read latency in clock cycles; only 1 or 2 are legal, any other value is an elaboration error.
- CLR_VAL, 0: DW-bit value written to every word by the clear sequencer.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- addr_in, in, AW: write address.
- data_in, in, DW: write data.
- regwrite, in, 1: write enable.
- addr_out, in, AW: read address.
- regread, in, 1: read enable.
- data_out, out, DW: read data.
- data_valid, out, 1: one-cycle strobe marking a read result on data_out.
- clear_req, in, 1: start a full-memory clear.
- busy, out, 1: high while the clear sequencer is running.
- wr_err, out, 1: one-cycle pulse flagging a rejected out-of-range write.

Behaviour:
- Reset (rst=1 at an edge):
  - data_out=0, data_valid=0, busy=0, wr_err=0.
  - Read pipeline flushed; clear FSM goes to IDLE.
  - Memory contents are not altered.
- Write acceptance:
  - A write is accepted when regwrite=1, busy=0 and addr_in<DEPTH. data_in is stored at that edge.
  - If regwrite=1, busy=0 and addr_in≥DEPTH: memory is untouched and wr_err=1 on the next cycle, for exactly one cycle.
  - If regwrite=1 and busy=1: the write is dropped silently and wr_err stays 0.
- Read acceptance:
  - A read is accepted when regread=1 and busy=0.
  - The result appears on data_out RD_LAT cycles after the accepting edge, with data_valid=1 for that one cycle.
  - Back-to-back reads give one result per cycle, in order.
  - If addr_out≥DEPTH: data_out=0 and data_valid=1 at the normal latency.
- Idle read port:
  - With regread=0, or regread=1 while busy=1, no read is issued and no data_valid is produced for that cycle.
  - data_out holds its last value.
  - Reads accepted before busy rose still complete normally.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE→CLEAR: on clear_req=1. busy=1 from the next cycle; internal counter starts at 0.
  - CLEAR: writes CLR_VAL to mem[counter] each cycle and increments the counter. After writing DEPTH-1 it moves to DONE.
  - DONE: busy=0, then IDLE on the next edge. Total busy time is DEPTH cycles.
  - clear_req while in CLEAR or DONE is ignored.
- Simultaneous clear_req and accepted write in IDLE: the write is performed; the clear later overwrites it with CLR_VAL.
- Reset during CLEAR: the sequence aborts next edge with busy=0. Memory is left partially cleared, words 0..counter-1 holding CLR_VAL.
- Read/write same address, same edge, default: read-first, so the read returns the old word.

Optional Feature:
- Macro FB_BYPASS_EN.
- When defined: an accepted read and accepted write to the same in-range address on the same edge returns the new data_in value (write-through forwarding), at the normal RD_LAT.
- When undefined: read-first behaviour as above. No forwarding logic is built.

Test Plan:
- Default params, write mem[0]=16'hAAAA, mem[1]=16'h8642, mem[2]=16'hFFFF, mem[3]=16'hAAAF. Then read addresses 3, 1, 0 back-to-back -> data_out = AAAF, 8642, AAAA on consecutive cycles, each with data_valid=1, first result 1 cycle after the first read edge. Repeat with RD_LAT=2 -> same values, shifted by one cycle.
- Write addr_in=76800, data 16'h1234 -> wr_err high for exactly one cycle. A subsequent read of addr 76799 is unchanged. A read of addr 76800 returns 0 with data_valid=1.
- DEPTH=16, CLR_VAL=16'h0F0F: fill with 16'h5555, pulse clear_req -> busy high for 16 cycles. Writes issued during busy are dropped. Afterwards all 16 words read 16'h0F0F.
- DEPTH=16: pulse clear_req, assert rst after 5 busy cycles -> busy=0 next cycle. Words 0–4 = CLR_VAL; words 5–15 keep their old data.
- Same-edge write 16'hBEEF and read of addr 7, old value 16'h0001 -> data_out=16'h0001 without FB_BYPASS_EN; 16'hBEEF with FB_BYPASS_EN.
- Reads every cycle, then regread=0 for 3 cycles -> data_valid=0 and data_out holds the last value. Reads issued while busy=1 produce no data_valid.
